// File: rtl/dds_wave_reader_if.sv
// ROM read port and DAC sample stream of the DDS wave reader.
// master = reader engine, slave = ROM model / DAC side.
interface dds_wave_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              rom_ce;
  logic              rom_oce;
  logic              rom_reset;
  logic [ADDR_W-1:0] rom_ad;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              dac_ready;
  logic              dac_sof;

  modport master (
    output rom_ce, rom_oce, rom_reset, rom_ad,
    output dac_data, dac_valid, dac_sof,
    input  rom_dout, dac_ready
  );

  modport slave (
    input  rom_ce, rom_oce, rom_reset, rom_ad,
    input  dac_data, dac_valid, dac_sof,
    output rom_dout, dac_ready
  );
endinterface

// File: rtl/dds_wave_reader.sv
// Phase-accumulator DDS reader: drives a bypass-mode 2048x8 pROM and streams samples to a DAC.
// Latency: ROM issue one cycle after RUN entry, sample valid two edges later; 1 sample/clk when ready.
// Backpressure: dac_ready low freezes issue and capture; the ROM holds dout. Optional AMP_SCALE_EN adds amp[8:0].
module dds_wave_reader #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [ADDR_W-1:0]  phase_off,
`ifdef AMP_SCALE_EN
  input  logic [8:0]         amp,
`endif
  output logic               busy,
  dds_wave_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [PHASE_W-1:0]  acc_q;
  logic [PHASE_W-1:0]  ftw_act_q;
  logic [PHASE_W-1:0]  ftw_shd_q;
  logic                inflight_q;
  logic                sof_pend_q;
  logic                sof_q;
  logic [DATA_W-1:0]   dac_data_q;
  logic                dac_valid_q;
  logic                dac_sof_q;

  logic                adv;
  logic                issue;
  logic                capture;
  logic                carry;
  logic [PHASE_W-1:0]  acc_d;
  logic [PHASE_W-1:0]  ftw_act_d;
  logic [DATA_W-1:0]   sample_d;

  assign adv     = !dac_valid_q || bus.dac_ready;
  assign issue   = (state_q == RUN) && adv;
  assign capture = inflight_q && adv;

  assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, ftw_act_q};
  // A load on the same edge as the activation wins over the old shadow value.
  assign ftw_act_d = ftw_load ? ftw : ftw_shd_q;

`ifdef AMP_SCALE_EN
  logic [8:0]        amp_eff;
  logic [DATA_W+8:0] prod;
  assign amp_eff  = (amp > 9'd256) ? 9'd256 : amp;
  assign prod     = {9'd0, bus.rom_dout} * {{DATA_W{1'b0}}, amp_eff};
  assign sample_d = prod[DATA_W+7:8];
`else
  assign sample_d = bus.rom_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ftw_act_q   <= '0;
      ftw_shd_q   <= '0;
      inflight_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      sof_q       <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      dac_sof_q   <= 1'b0;
    end else begin
      if (ftw_load) ftw_shd_q <= ftw;

      case (state_q)
        IDLE: if (enable) begin
          state_q    <= RUN;
          acc_q      <= '0;
          ftw_act_q  <= ftw_act_d;
          sof_pend_q <= 1'b1;
        end
        RUN: if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable)                            state_q <= RUN;
          else if (!inflight_q && !dac_valid_q)  state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Retune only at the wrap so the new frequency starts at phase zero.
      if (issue) begin
        acc_q      <= acc_d;
        inflight_q <= 1'b1;
        sof_q      <= sof_pend_q;
        sof_pend_q <= carry;
        if (carry) ftw_act_q <= ftw_act_d;
      end else if (adv) begin
        inflight_q <= 1'b0;
      end

      if (capture) begin
        dac_data_q  <= sample_d;
        dac_valid_q <= 1'b1;
        dac_sof_q   <= sof_q;
      end else if (bus.dac_ready) begin
        dac_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rom_ce    = issue;
  assign bus.rom_oce   = 1'b1;
  assign bus.rom_reset = (state_q == IDLE);
  assign bus.rom_ad    = acc_q[PHASE_W-1 -: ADDR_W] + phase_off;
  assign bus.dac_data  = dac_data_q;
  assign bus.dac_valid = dac_valid_q;
  assign bus.dac_sof   = dac_sof_q;
  assign busy          = (state_q != IDLE);

endmodule
